// File: rtl/beta_isa_pkg.sv
// Beta ISA constants shared by the program loader: ALU function codes,
// opcodes, instruction classes and the loader FSM states.
package beta_isa_pkg;

  localparam logic [3:0] FN_NOP   = 4'd0;
  localparam logic [3:0] FN_ADD   = 4'd1;
  localparam logic [3:0] FN_SUB   = 4'd2;
  localparam logic [3:0] FN_MUL   = 4'd3;
  localparam logic [3:0] FN_DIV   = 4'd4;
  localparam logic [3:0] FN_CMPEQ = 4'd5;
  localparam logic [3:0] FN_CMPLT = 4'd6;
  localparam logic [3:0] FN_CMPLE = 4'd7;
  localparam logic [3:0] FN_AND   = 4'd8;
  localparam logic [3:0] FN_OR    = 4'd9;
  localparam logic [3:0] FN_XOR   = 4'd10;
  localparam logic [3:0] FN_SHL   = 4'd11;
  localparam logic [3:0] FN_SHR   = 4'd12;
  localparam logic [3:0] FN_SRA   = 4'd13;

  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h21;
  localparam logic [5:0] OP_MUL   = 6'h22;
  localparam logic [5:0] OP_DIV   = 6'h23;
  localparam logic [5:0] OP_CMPEQ = 6'h24;
  localparam logic [5:0] OP_CMPLT = 6'h25;
  localparam logic [5:0] OP_CMPLE = 6'h26;
  localparam logic [5:0] OP_AND   = 6'h28;
  localparam logic [5:0] OP_OR    = 6'h29;
  localparam logic [5:0] OP_XOR   = 6'h2A;
  localparam logic [5:0] OP_SHL   = 6'h2C;
  localparam logic [5:0] OP_SHR   = 6'h2D;
  localparam logic [5:0] OP_SRA   = 6'h2E;
  localparam logic [5:0] OP_LD    = 6'h18;
  localparam logic [5:0] OP_ST    = 6'h19;
  localparam logic [5:0] OP_JMP   = 6'h1B;
  localparam logic [5:0] OP_BEQ   = 6'h1D;
  localparam logic [5:0] OP_BNE   = 6'h1E;

  localparam logic [5:0] OPC_OFFSET = 6'h10;

  typedef enum logic [2:0] {
    CL_OP, CL_OPC, CL_LD, CL_ST, CL_JMP, CL_BEQ, CL_BNE, CL_RSVD
  } iclass_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE
  } state_e;

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  func;
    logic [4:0]  rc;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [15:0] lit;
  } fields_t;

  // Register-form opcode for an ALU function; 0 marks an undecodable func.
  function automatic logic [5:0] alu_opcode(input logic [3:0] func);
    case (func)
      FN_ADD:   return OP_ADD;
      FN_SUB:   return OP_SUB;
      FN_MUL:   return OP_MUL;
      FN_DIV:   return OP_DIV;
      FN_CMPEQ: return OP_CMPEQ;
      FN_CMPLT: return OP_CMPLT;
      FN_CMPLE: return OP_CMPLE;
      FN_AND:   return OP_AND;
      FN_OR:    return OP_OR;
      FN_XOR:   return OP_XOR;
      FN_SHL:   return OP_SHL;
      FN_SHR:   return OP_SHR;
      FN_SRA:   return OP_SRA;
      default:  return 6'h00;
    endcase
  endfunction

endpackage

// File: rtl/beta_op_encode.sv
// Combinational packer: symbolic instruction fields to a 32-bit Beta word,
// flagging encodings the decoder would turn into an all-zero control word.
module beta_op_encode
  import beta_isa_pkg::*;
(
  input  fields_t     f,
  output logic [31:0] word,
  output logic        illegal
);

  logic [5:0] alu_op;
  assign alu_op = alu_opcode(f.func);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (iclass_e'(f.cls))
      CL_OP: begin
        illegal = (alu_op == 6'h00);
        word    = {alu_op, f.rc, f.ra, f.rb, 11'b0};
      end
      CL_OPC: begin
        illegal = (alu_op == 6'h00);
        word    = {alu_op + OPC_OFFSET, f.rc, f.ra, f.lit};
      end
      CL_LD:   word = {OP_LD,  f.rc, f.ra, f.lit};
      CL_ST:   word = {OP_ST,  f.rc, f.ra, f.lit};
      CL_JMP:  word = {OP_JMP, f.rc, f.ra, 16'b0};
      CL_BEQ:  word = {OP_BEQ, f.rc, f.ra, f.lit};
      CL_BNE:  word = {OP_BNE, f.rc, f.ra, f.lit};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/beta_instr_encoder.sv
// Beta program loader: accepts symbolic instructions, encodes them and writes
// them to sequential instruction-memory addresses over a req/gnt port.
module beta_instr_encoder
  import beta_isa_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        in_func,
  input  logic [4:0]        in_rc,
  input  logic [4:0]        in_ra,
  input  logic [4:0]        in_rb,
  input  logic [15:0]       in_lit,
  input  logic              in_last,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic              wrap,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  state_e      state_q, state_d;
  logic        last_q;
  fields_t     f;
  logic [31:0] enc_word;
  logic        enc_ill;

  assign f = '{cls: in_class, func: in_func, rc: in_rc, ra: in_ra, rb: in_rb, lit: in_lit};

  beta_op_encode u_enc (
    .f       (f),
    .word    (enc_word),
    .illegal (enc_ill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_req  = 1'b0;
    busy     = (state_q != ST_IDLE);
    done     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        in_ready = 1'b1;
        // an illegal last instruction still ends the session
        if (in_valid) begin
          if (!enc_ill)     state_d = ST_WRITE;
          else if (in_last) state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = last_q ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q    <= 1'b0;
      mem_addr  <= BASE;
      mem_wdata <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
      wrap      <= 1'b0;
      count     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          mem_addr <= BASE;
          count    <= '0;
          err      <= 1'b0;
          wrap     <= 1'b0;
        end
        ST_LOAD: if (in_valid) begin
          if (enc_ill) begin
            err <= 1'b1;
            if (!err) err_addr <= mem_addr;
          end else begin
            mem_wdata <= enc_word;
            last_q    <= in_last;
          end
        end
        ST_WRITE: if (mem_gnt) begin
          mem_addr <= mem_addr + ADDR_W'(1);
          if (&mem_addr) wrap <= 1'b1;
          if (count != '1) count <= count + (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_instr_encoder.sv
// Bench for the Beta program loader: two instances (default and a tiny
// 2-bit address space) share stimulus and are checked against a session model.
module tb_beta_instr_encoder;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, mem_gnt = 1'b0;
  logic [2:0]  in_class = '0;
  logic [3:0]  in_func = '0;
  logic [4:0]  in_rc = '0, in_ra = '0, in_rb = '0;
  logic [15:0] in_lit = '0;

  logic        rdy_a, req_a, busy_a, done_a, err_a, wrap_a;
  logic [9:0]  addr_a, eaddr_a;
  logic [31:0] wd_a;
  logic [10:0] cnt_a;
  logic        rdy_b, req_b, busy_b, done_b, err_b, wrap_b;
  logic [1:0]  addr_b, eaddr_b;
  logic [31:0] wd_b;
  logic [2:0]  cnt_b;

  beta_instr_encoder u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_a),
    .in_class(in_class), .in_func(in_func), .in_rc(in_rc), .in_ra(in_ra), .in_rb(in_rb),
    .in_lit(in_lit), .in_last(in_last), .mem_req(req_a), .mem_gnt(mem_gnt),
    .mem_addr(addr_a), .mem_wdata(wd_a), .busy(busy_a), .done(done_a), .err(err_a),
    .err_addr(eaddr_a), .wrap(wrap_a), .count(cnt_a)
  );

  beta_instr_encoder #(.ADDR_W(2), .BASE_ADDR(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy_b),
    .in_class(in_class), .in_func(in_func), .in_rc(in_rc), .in_ra(in_ra), .in_rb(in_rb),
    .in_lit(in_lit), .in_last(in_last), .mem_req(req_b), .mem_gnt(mem_gnt),
    .mem_addr(addr_b), .mem_wdata(wd_b), .busy(busy_b), .done(done_b), .err(err_b),
    .err_addr(eaddr_b), .wrap(wrap_b), .count(cnt_b)
  );

  always #5 clk = ~clk;

  int nerr = 0, nchk = 0;
  int gnt_mode = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ISA tables straight from the opcode map
  int alu_tab[16] = '{0, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26,
                      'h28, 'h29, 'h2A, 'h2C, 'h2D, 'h2E, 0, 0};
  int cls_tab[8]  = '{0, 0, 'h18, 'h19, 'h1B, 'h1D, 'h1E, 0};

  function automatic void ref_enc(input logic [2:0] c, input logic [3:0] fn,
                                  input logic [4:0] rc, input logic [4:0] ra,
                                  input logic [4:0] rb, input logic [15:0] lit,
                                  output logic [31:0] w, output bit ill);
    logic [5:0] op;
    w = '0; ill = 1'b0;
    if (c == 3'd0 || c == 3'd1) begin
      ill = (alu_tab[fn] == 0);
      op  = 6'(alu_tab[fn] + ((c == 3'd1) ? 16 : 0));
      w   = (c == 3'd0) ? {op, rc, ra, rb, 11'b0} : {op, rc, ra, lit};
    end else if (c == 3'd7) begin
      ill = 1'b1;
    end else begin
      op = 6'(cls_tab[c]);
      w  = (c == 3'd4) ? {op, rc, ra, 16'b0} : {op, rc, ra, lit};
    end
  endfunction

  // session-level model: one entry per instance
  int     m_busy[2], m_done[2], m_wait[2], m_last[2], m_addr[2], m_err[2], m_ea[2], m_wrap[2], m_cnt[2];
  longint m_wd[2];
  int     amask[2] = '{1023, 3};
  int     abase[2] = '{0, 3};
  int     cmax[2]  = '{2047, 7};
  int     la_addr[$], lb_addr[$];
  longint la_data[$];

  task automatic step(input int i, input logic b, input logic d, input logic rdy, input logic req,
                      input logic [63:0] addr, input logic [63:0] wd, input logic e,
                      input logic [63:0] ea, input logic w, input logic [63:0] cnt);
    logic [31:0] word;
    bit ill;
    int nd;
    if (mon_en) begin
      chk($sformatf("busy%0d", i), b, m_busy[i]);
      chk($sformatf("done%0d", i), d, m_done[i]);
      chk($sformatf("in_ready%0d", i), rdy, (m_busy[i] != 0 && m_done[i] == 0 && m_wait[i] == 0));
      chk($sformatf("mem_req%0d", i), req, m_wait[i]);
      chk($sformatf("mem_addr%0d", i), addr, m_addr[i]);
      chk($sformatf("mem_wdata%0d", i), wd, m_wd[i]);
      chk($sformatf("err%0d", i), e, m_err[i]);
      chk($sformatf("err_addr%0d", i), ea, m_ea[i]);
      chk($sformatf("wrap%0d", i), w, m_wrap[i]);
      chk($sformatf("count%0d", i), cnt, m_cnt[i]);
    end
    if (!rst_n) begin
      m_busy[i] = 0; m_done[i] = 0; m_wait[i] = 0; m_last[i] = 0; m_addr[i] = abase[i];
      m_wd[i] = 0; m_err[i] = 0; m_ea[i] = 0; m_wrap[i] = 0; m_cnt[i] = 0;
    end else begin
      nd = 0;
      if (m_done[i] != 0) m_busy[i] = 0;
      else if (m_busy[i] == 0) begin
        if (start) begin
          m_busy[i] = 1; m_addr[i] = abase[i]; m_cnt[i] = 0; m_err[i] = 0; m_wrap[i] = 0;
        end
      end else if (m_wait[i] != 0) begin
        if (mem_gnt) begin
          if (i == 0) begin la_addr.push_back(m_addr[i]); la_data.push_back(m_wd[i]); end
          else lb_addr.push_back(m_addr[i]);
          if (m_addr[i] == amask[i]) m_wrap[i] = 1;
          m_addr[i] = (m_addr[i] + 1) & amask[i];
          if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          m_wait[i] = 0;
          if (m_last[i] != 0) nd = 1;
        end
      end else if (in_valid) begin
        ref_enc(in_class, in_func, in_rc, in_ra, in_rb, in_lit, word, ill);
        if (ill) begin
          if (m_err[i] == 0) m_ea[i] = m_addr[i];
          m_err[i] = 1;
          if (in_last) nd = 1;
        end else begin
          m_wd[i] = word; m_wait[i] = 1; m_last[i] = in_last;
        end
      end
      m_done[i] = nd;
    end
  endtask

  always @(negedge clk) begin
    step(0, busy_a, done_a, rdy_a, req_a, addr_a, wd_a, err_a, eaddr_a, wrap_a, cnt_a);
    step(1, busy_b, done_b, rdy_b, req_b, addr_b, wd_b, err_b, eaddr_b, wrap_b, cnt_b);
  end

  initial forever begin
    @(posedge clk); #2;
    case (gnt_mode)
      0:       mem_gnt = 1'b1;
      1:       mem_gnt = 1'($urandom_range(0, 1));
      default: mem_gnt = 1'b0;
    endcase
  end

  // all tasks below are entered and left 2ns after a rising edge
  task automatic begin_session();
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] c, input logic [3:0] fn, input logic [4:0] rc,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [15:0] lit,
                      input logic last);
    int k;
    k = 0;
    in_class = c; in_func = fn; in_rc = rc; in_ra = ra; in_rb = rb; in_lit = lit;
    in_last = last; in_valid = 1'b1;
    start = ($urandom_range(0, 3) == 0);
    do begin @(negedge clk); k++; end while (rdy_a !== 1'b1 && k < 300);
    chk("send_accept", rdy_a, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b0; start = 1'b0;
    in_class = 3'($urandom); in_func = 4'($urandom); in_lit = 16'($urandom); in_last = 1'($urandom);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (done_a !== 1'b1 && k < 400);
    chk("done_seen", done_a, 1'b1);
  endtask

  task automatic end_sess();
    @(negedge clk);
    chk("idle_busy", busy_a, 1'b0);
    chk("idle_done", done_a, 1'b0);
    @(posedge clk); #2;
  endtask

  task automatic clear_logs();
    la_addr.delete(); la_data.delete(); lb_addr.delete();
  endtask

  initial begin
    int n;
    logic [2:0] c;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [2:0] c;
    repeat (2) @(posedge clk);
    #2; mon_en = 1'b1;
    @(negedge clk);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_b", addr_b, 3);
    chk("rst_wdata", wd_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_ready", rdy_a, 0);
    chk("rst_req", req_a, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #2;

    // ADD, ADDC, LD(last) with immediate grants
    gnt_mode = 0; clear_logs();
    begin_session();
    send(3'd0, 4'd1, 5'd3, 5'd1, 5'd2, 16'd0, 1'b0);
    send(3'd1, 4'd1, 5'd1, 5'd31, 5'd0, 16'd5, 1'b0);
    send(3'd2, 4'd0, 5'd2, 5'd0, 5'd0, 16'd8, 1'b1);
    wait_done();
    chk("s1_nwrites", la_addr.size(), 3);
    if (la_addr.size() == 3 && lb_addr.size() == 3) begin
      chk("s1_add_word", la_data[0], 32'h80611000);
      chk("s1_add_addr", la_addr[0], 0);
      chk("s1_addc_word", la_data[1], 32'hC03F0005);
      chk("s1_ld_word", la_data[2], 32'h60400008);
      chk("s1_ld_addr", la_addr[2], 2);
      chk("s1_b_addr0", lb_addr[0], 3);
      chk("s1_b_addr1", lb_addr[1], 0);
    end
    chk("s1_count_a", cnt_a, 3);
    chk("s1_wrap_a", wrap_a, 0);
    chk("s1_wrap_b", wrap_b, 1);
    chk("s1_count_b", cnt_b, 3);
    end_sess();

    // illegal in the middle: err_addr captured, address not consumed
    clear_logs();
    begin_session();
    chk("s2_wrap_cleared", wrap_b, 0);
    chk("s2_count_cleared", cnt_b, 0);
    send(3'd0, 4'd1, 5'd4, 5'd5, 5'd6, 16'd0, 1'b0);
    send(3'd1, 4'd9, 5'd7, 5'd8, 5'd0, 16'hBEEF, 1'b0);
    send(3'd0, 4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 1'b0);
    send(3'd0, 4'd2, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1);
    wait_done();
    chk("s2_err_a", err_a, 1);
    chk("s2_err_addr_a", eaddr_a, 2);
    chk("s2_err_addr_b", eaddr_b, 1);
    if (la_addr.size() == 3) chk("s2_next_addr", la_addr[2], 2);
    chk("s2_count_a", cnt_a, 3);
    end_sess();

    // grant stall: five cycles of gnt=0, accepted on the sixth
    clear_logs();
    begin_session();
    chk("s3_err_cleared", err_a, 0);
    gnt_mode = 2;
    send(3'd3, 4'd0, 5'd4, 5'd5, 5'd0, 16'h1234, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_req", req_a, 1);
      chk("stall_addr", addr_a, 0);
      chk("stall_wdata", wd_a, 32'h64851234);
      chk("stall_ready", rdy_a, 0);
    end
    gnt_mode = 0;
    @(negedge clk);
    chk("stall_req6", req_a, 1);
    wait_done();
    chk("s3_count", cnt_a, 1);
    if (la_data.size() == 1) chk("s3_word", la_data[0], 32'h64851234);
    end_sess();

    // reset in the middle of a stalled write abandons the session
    gnt_mode = 2;
    begin_session();
    send(3'd4, 4'd0, 5'd9, 5'd10, 5'd0, 16'hFFFF, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1; gnt_mode = 0;
    @(negedge clk);
    chk("mrst_busy", busy_a, 0);
    chk("mrst_req", req_a, 0);
    chk("mrst_addr_b", addr_b, 3);
    chk("mrst_wdata", wd_a, 0);
    repeat (3) @(posedge clk);
    #2;

    // nine writes: count_b saturates at 7
    begin_session();
    for (int j = 0; j < 9; j++) send(3'd0, 4'd1, 5'(j), 5'd1, 5'd2, 16'd0, j == 8);
    wait_done();
    chk("sat_count_a", cnt_a, 9);
    chk("sat_count_b", cnt_b, 7);
    chk("sat_wrap_b", wrap_b, 1);
    end_sess();

    // randomized sessions, random grants, stray starts and idle valids
    for (int s = 0; s < 40; s++) begin
      n = $urandom_range(1, 12);
      gnt_mode = $urandom_range(0, 1);
      begin_session();
      for (int j = 0; j < n; j++) begin
        c = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
        send(c, 4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), j == n - 1);
      end
      wait_done();
      end_sess();
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #2;
      end
      in_valid = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
